// File: rtl/tbac_pipe.sv
// Truncated binary-antilogarithm converter (log-to-linear).
// Rebuilds (1.y) * 2^k from a log-domain word {k, y}, discarding every
// fraction bit shifted below the binary point. Two-stage pipeline with
// valid/ready on both sides; stage 1 decodes the shift, stage 2 shifts.
module tbac_pipe #(
  parameter int M  = 5,
  parameter int FW = 16 - M,
  parameter int KW = 5,
  parameter int OW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_zero,
  input  logic [KW-1:0] in_k,
  input  logic [FW-1:0] in_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_p
);

  localparam logic [KW-1:0] FW_K = KW'(FW);

  // Pipeline control
  logic          s1_valid;
  logic          s2_valid;
  logic          adv2;
  logic          accept;

  // Stage-1 decode of the incoming word
  logic          dir_left;
  logic [KW-1:0] sh_amt;

  // Stage-1 registers
  logic          zero_p1;
  logic          left_p1;
  logic [FW:0]   m_p1;
  logic [KW-1:0] sh_p1;

  // Stage-2 combinational shift result
  logic [OW-1:0] shifted_p1;

  // Scale the mantissa by 2^(k-FW); a right shift simply drops the
  // fractional bits, which is the truncation the log multiplier expects.
  function automatic logic [OW-1:0] trunc_shift(input logic [FW:0]   m,
                                                input logic          left,
                                                input logic [KW-1:0] sh);
    logic [OW-1:0] wide;
    wide = OW'(m);
    if (left)
      return wide << sh;
    else
      return wide >> sh;
  endfunction

  assign adv2      = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~s1_valid | adv2;
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;

  assign dir_left  = (in_k >= FW_K);
  assign sh_amt    = dir_left ? (in_k - FW_K) : (FW_K - in_k);

  // Valid bits for both stages: set on load, cleared when drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (accept)
        s1_valid <= 1'b1;
      else if (adv2)
        s1_valid <= 1'b0;

      if (adv2)
        s2_valid <= 1'b1;
      else if (out_ready)
        s2_valid <= 1'b0;
    end
  end

  // ---- stage 1: capture mantissa, zero flag and decoded shift ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_p1 <= 1'b0;
      left_p1 <= 1'b0;
      m_p1    <= '0;
      sh_p1   <= '0;
    end else if (accept) begin
      zero_p1 <= in_zero;
      left_p1 <= dir_left;
      m_p1    <= {1'b1, in_y};
      sh_p1   <= sh_amt;
    end
  end

  assign shifted_p1 = trunc_shift(m_p1, left_p1, sh_p1);

  // ---- stage 2: barrel shift with zero mask, held while stalled ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_p <= '0;
    else if (adv2)
      out_p <= zero_p1 ? '0 : shifted_p1;
  end

endmodule

// File: tb/tb_tbac_pipe.sv
// Directed and random bench for tbac_pipe with an in-order scoreboard.
module tb_tbac_pipe;

  localparam int FW = 11;
  localparam int KW = 5;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_zero;
  logic [KW-1:0] in_k;
  logic [FW-1:0] in_y;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_p;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_out    = 0;
  int n_acc    = 0;
  bit lat_chk  = 1'b0;

  logic [OW-1:0] exp_q[$];
  int            acc_q[$];
  logic [OW-1:0] mon_e;
  int            mon_a;

  tbac_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_zero   (in_zero),
    .in_k      (in_k),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] model(input bit z, input logic [KW-1:0] k, input logic [FW-1:0] y);
    logic [63:0] w;
    w = 64'({1'b1, y}) << k;
    w = w >> FW;
    return z ? '0 : w[OW-1:0];
  endfunction

  // Output side of the scoreboard plus acceptance bookkeeping
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_a = acc_q.pop_front();
          check("out_p", out_p, mon_e);
          if (lat_chk) check("latency", 32'(cyc - mon_a), 32'd2);
        end
      end
      if (in_valid && in_ready) begin
        acc_q.push_back(cyc);
        n_acc++;
      end
    end
  end

  task automatic drive(input bit z, input logic [KW-1:0] k, input logic [FW-1:0] y,
                       input logic [OW-1:0] e);
    in_valid = 1'b1;
    in_zero  = z;
    in_k     = k;
    in_y     = y;
    exp_q.push_back(e);
  endtask

  task automatic wait_accept(input string tag);
    bit got;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) return;
    end
    check({tag, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_zero   = 1'b0;
    in_k      = '0;
    in_y      = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_p",     out_p,          32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic values, one per cycle, fixed latency
    lat_chk = 1'b1;
    drive(1'b0, 5'd0,  11'h000, 32'd1);          wait_accept("b0");
    drive(1'b0, 5'd11, 11'h000, 32'd2048);       wait_accept("b1");
    drive(1'b0, 5'd3,  11'h400, 32'd12);         wait_accept("b2");
    drive(1'b0, 5'd12, 11'h200, 32'd5120);       wait_accept("b3");
    drive(1'b0, 5'd31, 11'h7FF, 32'hFFF0_0000);  wait_accept("b4");
    // Truncation and zero
    drive(1'b0, 5'd2,  11'h7FF, 32'd7);          wait_accept("t0");
    drive(1'b0, 5'd10, 11'h001, 32'd1024);       wait_accept("t1");
    drive(1'b1, 5'd31, 11'h7FF, 32'd0);          wait_accept("z0");
    in_valid = 1'b0;
    drain("basic");

    // Backpressure: two items fill the pipe, the third must wait
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 5'd5,  11'h000, 32'd32);         wait_accept("bp0");
    drive(1'b0, 5'd20, 11'h100, 32'h0012_0000);  wait_accept("bp1");
    drive(1'b0, 5'd0,  11'h7FF, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_hold",      out_p,          32'd32);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_accept("bp2");
    drive(1'b0, 5'd15, 11'h555, 32'd54608);      wait_accept("bp3");
    in_valid = 1'b0;
    drain("bp");

    // Full throughput with random operands
    lat_chk = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bit            z;
      logic [KW-1:0] k;
      logic [FW-1:0] y;
      z = ($urandom_range(0, 7) == 0);
      k = KW'($urandom_range(0, 31));
      y = FW'($urandom);
      drive(z, k, y, model(z, k, y));
      @(negedge clk);
      check("tput_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain("tput");
    check("count_match", 32'(n_out), 32'(n_acc));

    // Reset mid-stream with both stages occupied
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 5'd31, 11'h7FF, 32'hFFF0_0000);  wait_accept("r0");
    drive(1'b0, 5'd12, 11'h200, 32'd5120);       wait_accept("r1");
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_p",     out_p,          32'd0);
    check("async_rst_in_ready",  32'(in_ready),  32'd1);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
